mem_arbiter: RTL and testbench

//   Shares the single-port program/data memory between the CPU control unit and a DMA requester.

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU control unit and
// a DMA requester. At most one side is granted per cycle. A per-side
// consecutive-grant limit stops either side from starving the other. Read data
// returns one cycle after the grant, steered to the side that issued the read.
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int CPU_LIMIT = 4,
  parameter int DMA_LIMIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int MAX_LIMIT = (CPU_LIMIT > DMA_LIMIT) ? CPU_LIMIT : DMA_LIMIT;
  localparam int CW        = $clog2(MAX_LIMIT + 1);

  localparam logic [CW-1:0] CPU_LIM  = CW'(CPU_LIMIT);
  localparam logic [CW-1:0] DMA_LIM  = CW'(DMA_LIMIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  owner_t        owner;
  owner_t        owner_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          rd_pend;
  logic          rd_pend_next;
  owner_t        rd_who;
  owner_t        rd_who_next;

  logic          own_req;
  logic          oth_req;
  logic [CW-1:0] own_lim;
  logic          grant_owner;
  logic          grant_other;
  logic          cpu_win;
  logic          dma_win;

  // Arbitration: owner keeps the bus until its run limit is hit while the other side waits.
  always_comb begin
    own_req     = 1'b0;
    oth_req     = 1'b0;
    own_lim     = CPU_LIM;
    grant_owner = 1'b0;
    grant_other = 1'b0;
    cpu_win     = 1'b0;
    dma_win     = 1'b0;
    case (owner)
      OWN_CPU: begin
        own_req = cpu_req;
        oth_req = dma_req;
        own_lim = CPU_LIM;
      end
      OWN_DMA: begin
        own_req = dma_req;
        oth_req = cpu_req;
        own_lim = DMA_LIM;
      end
      default: begin
        own_req = cpu_req;
        oth_req = dma_req;
        own_lim = CPU_LIM;
      end
    endcase
    if (own_req && ((cnt < own_lim) || !oth_req)) begin
      grant_owner = 1'b1;
    end else if (oth_req) begin
      grant_other = 1'b1;
    end else begin
      grant_owner = 1'b0;
      grant_other = 1'b0;
    end
    // Nothing reaches memory while reset is held.
    if (rst) begin
      cpu_win = 1'b0;
      dma_win = 1'b0;
    end else if (owner == OWN_CPU) begin
      cpu_win = grant_owner;
      dma_win = grant_other;
    end else begin
      cpu_win = grant_other;
      dma_win = grant_owner;
    end
  end

  // Next-state: run-length counter, ownership hand-over and read tracking.
  always_comb begin
    owner_next   = owner;
    cnt_next     = cnt;
    rd_pend_next = 1'b0;
    rd_who_next  = rd_who;
    if (grant_owner) begin
      if (cnt >= own_lim) begin
        cnt_next = own_lim;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end else if (grant_other) begin
      owner_next = (owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
      cnt_next   = CNT_ONE;
    end else begin
      cnt_next = CNT_ZERO;
    end
    if (cpu_win && !cpu_we) begin
      rd_pend_next = 1'b1;
      rd_who_next  = OWN_CPU;
    end else if (dma_win && !dma_we) begin
      rd_pend_next = 1'b1;
      rd_who_next  = OWN_DMA;
    end else begin
      rd_pend_next = 1'b0;
      rd_who_next  = rd_who;
    end
  end

  // State registers; reset drops any outstanding read so no stale rvalid escapes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= OWN_CPU;
      cnt     <= CNT_ZERO;
      rd_pend <= 1'b0;
      rd_who  <= OWN_CPU;
    end else begin
      owner   <= owner_next;
      cnt     <= cnt_next;
      rd_pend <= rd_pend_next;
      rd_who  <= rd_who_next;
    end
  end

  // Memory mux: route the winner's request, drive zeros when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_win) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {AW{1'b0}};
      mem_wdata = {DW{1'b0}};
    end
  end

  // Read return: memory data goes only to the side that issued the pending read.
  always_comb begin
    cpu_gnt    = cpu_win;
    dma_gnt    = dma_win;
    cpu_rvalid = 1'b0;
    dma_rvalid = 1'b0;
    cpu_rdata  = {DW{1'b0}};
    dma_rdata  = {DW{1'b0}};
    if (!rst && rd_pend && (rd_who == OWN_CPU)) begin
      cpu_rvalid = 1'b1;
      cpu_rdata  = mem_rdata;
    end else if (!rst && rd_pend && (rd_who == OWN_DMA)) begin
      dma_rvalid = 1'b1;
      dma_rdata  = mem_rdata;
    end else begin
      cpu_rvalid = 1'b0;
      dma_rvalid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a directed vector table from reset, hand-written
// sequences for saturation / idle hand-back / reset-during-read, then random
// traffic checked against a behavioural model of the arbitration rules.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CPU_LIMIT = 4;
  localparam int DMA_LIMIT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .CPU_LIMIT(CPU_LIMIT), .DMA_LIMIT(DMA_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        creq, cwe;
    logic [15:0] caddr, cwd;
    logic        dreq, dwe;
    logic [15:0] daddr, dwd;
    logic [15:0] mrd;
    logic        egc, egd, ervc;
    logic [15:0] erdc;
    logic        ervd;
    logic [15:0] erdd;
    logic        een, ewe;
    logic [15:0] eaddr, ewd;
  } vec_t;

  function automatic vec_t mk(
    input logic creq, input logic cwe, input logic [15:0] caddr, input logic [15:0] cwd,
    input logic dreq, input logic dwe, input logic [15:0] daddr, input logic [15:0] dwd,
    input logic [15:0] mrd,
    input logic egc, input logic egd, input logic ervc, input logic [15:0] erdc,
    input logic ervd, input logic [15:0] erdd,
    input logic een, input logic ewe, input logic [15:0] eaddr, input logic [15:0] ewd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.mrd = mrd;
    v.egc = egc; v.egd = egd; v.ervc = ervc; v.erdc = erdc;
    v.ervd = ervd; v.erdd = erdd;
    v.een = een; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    chk({tag, ".cpu_gnt"},    {15'd0, cpu_gnt},    {15'd0, e.egc});
    chk({tag, ".dma_gnt"},    {15'd0, dma_gnt},    {15'd0, e.egd});
    chk({tag, ".cpu_rvalid"}, {15'd0, cpu_rvalid}, {15'd0, e.ervc});
    chk({tag, ".cpu_rdata"},  cpu_rdata,           e.erdc);
    chk({tag, ".dma_rvalid"}, {15'd0, dma_rvalid}, {15'd0, e.ervd});
    chk({tag, ".dma_rdata"},  dma_rdata,           e.erdd);
    chk({tag, ".mem_en"},     {15'd0, mem_en},     {15'd0, e.een});
    chk({tag, ".mem_we"},     {15'd0, mem_we},     {15'd0, e.ewe});
    chk({tag, ".mem_addr"},   mem_addr,            e.eaddr);
    chk({tag, ".mem_wdata"},  mem_wdata,           e.ewd);
  endtask

  task automatic drive(input vec_t v);
    cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    dma_req = v.dreq; dma_we = v.dwe; dma_addr = v.daddr; dma_wdata = v.dwd;
    mem_rdata = v.mrd;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 16'h0000;
    mem_rdata = 16'h0000;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
  endtask

  vec_t tbl[11];
  vec_t zero_v;
  vec_t e;

  // Behavioural reference: who holds the bus and how long its current run is.
  int   m_holder;   // 0 = CPU, 1 = DMA
  int   m_run;      // consecutive grants to holder (unbounded)
  int   m_rd_side;  // -1 none, 0 CPU, 1 DMA
  int   g;          // -1 none, 0 CPU, 1 DMA

  initial begin
    rst = 1'b1;
    idle_inputs();
    zero_v = mk(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 16'h0, 0,0,0,16'h0,0,16'h0,0,0,16'h0,16'h0);

    //                creq cwe caddr     cwd        dreq dwe daddr     dwd        mrd        gc gd rvc rdc        rvd rdd        en we addr       wdata
    tbl[0]  = mk(1,0,16'h0010,16'h1111, 1,0,16'h0040,16'h2222, 16'h0000, 1,0,0,16'h0000,0,16'h0000, 1,0,16'h0010,16'h1111);
    tbl[1]  = mk(1,0,16'h0010,16'h1111, 1,0,16'h0040,16'h2222, 16'hAAAA, 1,0,1,16'hAAAA,0,16'h0000, 1,0,16'h0010,16'h1111);
    tbl[2]  = mk(1,1,16'h1234,16'h5A5A, 1,0,16'h0040,16'h2222, 16'hBBBB, 1,0,1,16'hBBBB,0,16'h0000, 1,1,16'h1234,16'h5A5A);
    tbl[3]  = mk(1,0,16'h0010,16'h1111, 1,0,16'h0040,16'h2222, 16'hCCCC, 1,0,0,16'h0000,0,16'h0000, 1,0,16'h0010,16'h1111);
    tbl[4]  = mk(1,0,16'h0010,16'h1111, 1,0,16'h0040,16'h2222, 16'hDDDD, 0,1,1,16'hDDDD,0,16'h0000, 1,0,16'h0040,16'h2222);
    tbl[5]  = mk(1,0,16'h0010,16'h1111, 1,0,16'h0040,16'h2222, 16'hBEEF, 0,1,0,16'h0000,1,16'hBEEF, 1,0,16'h0040,16'h2222);
    tbl[6]  = mk(1,0,16'h0010,16'h1111, 1,0,16'h0040,16'h2222, 16'h1357, 1,0,0,16'h0000,1,16'h1357, 1,0,16'h0010,16'h1111);
    tbl[7]  = mk(0,0,16'h0010,16'h1111, 0,0,16'h0040,16'h2222, 16'h2468, 0,0,1,16'h2468,0,16'h0000, 0,0,16'h0000,16'h0000);
    tbl[8]  = mk(0,1,16'hFFFF,16'h3333, 1,1,16'h0080,16'h7777, 16'h9999, 0,1,0,16'h0000,0,16'h0000, 1,1,16'h0080,16'h7777);
    tbl[9]  = mk(1,0,16'h0010,16'h1111, 0,0,16'h0080,16'h7777, 16'h0000, 1,0,0,16'h0000,0,16'h0000, 1,0,16'h0010,16'h1111);
    tbl[10] = mk(0,0,16'h0010,16'h1111, 0,0,16'h0080,16'h7777, 16'h4242, 0,0,1,16'h4242,0,16'h0000, 0,0,16'h0000,16'h0000);

    // Reset state: outputs stay zero under reset even with both sides requesting.
    repeat (2) @(posedge clk);
    #1;
    cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 16'h0101; dma_addr = 16'h0202;
    mem_rdata = 16'hFFFF;
    @(negedge clk);
    check_all("reset", zero_v);

    // Directed table starting in the first cycle after reset.
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      rst = 1'b0;
      drive(tbl[i]);
      @(negedge clk);
      check_all($sformatf("tbl%0d", i), tbl[i]);
    end

    // CPU alone for 10 cycles, then DMA appears and wins at once.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'(i); dma_req = 1'b0;
      mem_rdata = 16'(16'h0100 + i);
      @(negedge clk);
      chk($sformatf("solo%0d.cpu_gnt", i), {15'd0, cpu_gnt}, 16'd1);
      chk($sformatf("solo%0d.dma_gnt", i), {15'd0, dma_gnt}, 16'd0);
      if (i > 0) chk($sformatf("solo%0d.cpu_rdata", i), cpu_rdata, 16'(16'h0100 + i));
    end
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0555;
    @(negedge clk);
    chk("sat_compete.dma_gnt", {15'd0, dma_gnt}, 16'd1);
    chk("sat_compete.cpu_gnt", {15'd0, cpu_gnt}, 16'd0);

    // DMA takes the bus, idles one cycle, then competes: D, D, C.
    do_reset();
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("own_dma.dma_gnt", {15'd0, dma_gnt}, 16'd1);
    next_cycle();
    dma_req = 1'b0;
    @(negedge clk);
    chk("own_dma_idle.mem_en", {15'd0, mem_en}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b1; dma_req = 1'b1;
      @(negedge clk);
      chk($sformatf("own_dma%0d.dma_gnt", i), {15'd0, dma_gnt}, (i < 2) ? 16'd1 : 16'd0);
      chk($sformatf("own_dma%0d.cpu_gnt", i), {15'd0, cpu_gnt}, (i < 2) ? 16'd0 : 16'd1);
    end

    // Reset in the cycle after a granted CPU read: the read is dropped.
    do_reset();
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0777; dma_req = 1'b0;
    @(negedge clk);
    chk("rdrst.cpu_gnt", {15'd0, cpu_gnt}, 16'd1);
    next_cycle();
    rst = 1'b1; dma_req = 1'b1; mem_rdata = 16'hFACE;
    @(negedge clk);
    check_all("rdrst_during", zero_v);
    next_cycle();
    rst = 1'b0; cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b1; dma_we = 1'b1;
    @(negedge clk);
    chk("rdrst_after.cpu_rvalid", {15'd0, cpu_rvalid}, 16'd0);
    chk("rdrst_after.dma_rvalid", {15'd0, dma_rvalid}, 16'd0);
    chk("rdrst_after.cpu_gnt", {15'd0, cpu_gnt}, 16'd1);
    chk("rdrst_after.dma_gnt", {15'd0, dma_gnt}, 16'd0);

    // Random traffic against the behavioural model.
    do_reset();
    m_holder = 0; m_run = 0; m_rd_side = -1;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rst       = ($urandom_range(0, 63) == 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      dma_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      dma_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 16'($urandom);
      dma_addr  = 16'($urandom);
      cpu_wdata = 16'($urandom);
      dma_wdata = 16'($urandom);
      mem_rdata = 16'($urandom);

      e = zero_v;
      g = -1;
      if (!rst) begin
        bit hold_req, other_req;
        int lim;
        hold_req  = (m_holder == 0) ? cpu_req : dma_req;
        other_req = (m_holder == 0) ? dma_req : cpu_req;
        lim       = (m_holder == 0) ? CPU_LIMIT : DMA_LIMIT;
        if (hold_req && (m_run < lim || !other_req)) g = m_holder;
        else if (other_req) g = 1 - m_holder;
        else g = -1;
        if (g == 0) begin
          e.egc = 1'b1; e.een = 1'b1; e.ewe = cpu_we; e.eaddr = cpu_addr; e.ewd = cpu_wdata;
        end else if (g == 1) begin
          e.egd = 1'b1; e.een = 1'b1; e.ewe = dma_we; e.eaddr = dma_addr; e.ewd = dma_wdata;
        end
        if (m_rd_side == 0) begin
          e.ervc = 1'b1; e.erdc = mem_rdata;
        end else if (m_rd_side == 1) begin
          e.ervd = 1'b1; e.erdd = mem_rdata;
        end
      end

      @(negedge clk);
      check_all($sformatf("rnd%0d", n), e);

      if (rst) begin
        m_holder = 0; m_run = 0; m_rd_side = -1;
      end else begin
        if (g == m_holder) m_run++;
        else if (g >= 0) begin m_holder = g; m_run = 1; end
        else m_run = 0;
        if (g == 0 && !cpu_we) m_rd_side = 0;
        else if (g == 1 && !dma_we) m_rd_side = 1;
        else m_rd_side = -1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
